hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core. Drives the execute-stage operand-forward selects
//  (forwardAE/BE) and the decode branch-compare forwards. Generates load-use and branch stalls,
//  taken-branch flushes, and a whole-pipe freeze while the data memory is not ready.
//  Keeps a memory-wait FSM with timeout and saturating stall/flush counters for debug.
// PARAMETERS
//  REG_AW    5   register-address width
//  CNT_W     32  width of performance counters
//  MAX_WAIT  16  max consecutive dmem-wait cycles before memTimeout (>=1)
// PORTS
//  clk          in   1       core clock, rising edge
//  rst_n        in   1       synchronous reset, active low
//  rsD, rtD     in   REG_AW  decode source regs
//  rsE, rtE     in   REG_AW  execute source regs
//  writeRegE/M/W in  REG_AW  destination reg per stage
//  regWriteE/M/W in  1       stage writes register file
//  memToRegE/M  in   1       stage holds a load
//  branchD      in   1       decode holds a branch
//  pcSrcD       in   1       branch resolved taken in decode
//  memAccessM   in   1       memory stage issues a dmem access
//  dmemReady    in   1       dmem completes the access this cycle
//  forwardAE/BE out  2       00=regfile, 01=resultW, 10=aluOutM (11 unused, never driven)
//  forwardAD/BD out  1       decode compare operand from aluOutM
//  stallF, stallD, stallE, stallM  out 1   hold pipeline register
//  flushD, flushE, flushW          out 1   bubble into pipeline register
//  memTimeout   out  1       sticky: dmem wait exceeded MAX_WAIT
//  stallCycles  out  CNT_W   cycles with stallF asserted (saturating)
//  flushCount   out  CNT_W   cycles with flushD or flushE asserted (saturating)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FSM=RUN, wait counter=0, memTimeout=0, counters=0.
//  All comb outputs follow the inputs whenever rst_n is high.
//  Forwarding (comb, zero latency): forwardAE=10 if regWriteM && writeRegM!=0 && writeRegM==rsE;
//   else 01 if regWriteW && writeRegW!=0 && writeRegW==rsE; else 00. Same rule on rtE gives forwardBE.
//   M has priority over W. Register 0 is never forwarded.
//  forwardAD/BD=1 iff regWriteM && writeRegM!=0 && writeRegM==rsD/rtD.
//  lwStall = memToRegE && writeRegE!=0 && (writeRegE==rsD || writeRegE==rtD).
//  brStall = branchD && ((regWriteE && writeRegE!=0 && writeRegE in {rsD,rtD}) ||
//            (memToRegM && writeRegM!=0 && writeRegM in {rsD,rtD})).
//  memWait = memAccessM && !dmemReady.
//  Priority 1, memWait: stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0.
//   Whole pipe frozen; a pending branch flush or hazard is re-evaluated next cycle.
//  Priority 2, lwStall|brStall: stallF=stallD=1, flushE=1, flushD=0.
//  Priority 3, pcSrcD: flushD=1.
//  Otherwise all stall and flush outputs are 0.
//  FSM {RUN, MEM_WAIT}, registered:
//   RUN->MEM_WAIT on memWait. In MEM_WAIT the wait counter increments each cycle memWait holds.
//   MEM_WAIT->RUN on dmemReady or on !memAccessM; the wait counter clears on that transition.
//   When the counter reaches MAX_WAIT, memTimeout sets (sticky until reset).
//   The stall continues after timeout; there is no recovery other than reset.
//  Counters: increment by 1 per qualifying cycle and saturate at all-ones, no wrap.
//  Reset mid-wait: returns to RUN at once. Stall outputs still follow the comb inputs.
// STRUCTURE
//  Shared package: forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10,
//   and FSM state encoding.
//  Sub-module sat_counter #(CNT_W): inc, clk, rst_n -> count. Two instances.
//  Everything else is comb logic plus the FSM in this file.
// TESTING
//  1. rsE=3, regWriteM=1, writeRegM=3, regWriteW=1, writeRegW=3 -> forwardAE=10 (M wins).
//     Drop regWriteM -> forwardAE=01.
//  2. writeRegM=0 with regWriteM=1, rsE=0 -> forwardAE=00. Same with rtE=0 -> forwardBE=00.
//  3. memToRegE=1, writeRegE=5, rtD=5 -> stallF=stallD=flushE=1 for one cycle,
//     stallCycles +1, flushCount +1.
//  4. branchD=1, pcSrcD=1, no hazards -> flushD=1 only.
//     Add memWait in the same cycle -> flushD=0, all four stalls=1, flushW=1.
//  5. memAccessM=1, dmemReady low for 3 cycles then high -> stalls for exactly 3 cycles,
//     FSM returns to RUN, memTimeout=0.
//  6. dmemReady low for MAX_WAIT cycles -> memTimeout=1 and stays 1 after ready.
//     Pulse rst_n=0 -> memTimeout=0, counters=0, FSM=RUN.
//  7. Preload stallCycles near all-ones (CNT_W=4 build) -> holds at 4'hF.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard/sequencing unit: forward-select
// encodings and the memory-wait FSM state type.
package hazard_control_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard detection, forwarding selects, stall/flush generation and dmem-wait
// tracking for the 5-stage pipeline. Stall/flush/forward outputs are purely combinational.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeRegE,
  input  logic [REG_AW-1:0] writeRegM,
  input  logic [REG_AW-1:0] writeRegW,
  input  logic              regWriteE,
  input  logic              regWriteM,
  input  logic              regWriteW,
  input  logic              memToRegE,
  input  logic              memToRegM,
  input  logic              branchD,
  input  logic              pcSrcD,
  input  logic              memAccessM,
  input  logic              dmemReady,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushW,
  output logic              memTimeout,
  output logic [CNT_W-1:0]  stallCycles,
  output logic [CNT_W-1:0]  flushCount,
  output hcu_state_e        fsm_state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  hcu_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lw_stall;
  logic              br_stall;
  logic              mem_wait;

  // Register 0 is hardwired to zero, so a write to it never forwards or hazards.
  function automatic logic hits(input logic wr, input logic [REG_AW-1:0] dst,
                                input logic [REG_AW-1:0] src);
    return wr && (dst != '0) && (dst == src);
  endfunction

  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (hits(regWriteM, writeRegM, rsE))      forwardAE = FWD_MEM;
    else if (hits(regWriteW, writeRegW, rsE)) forwardAE = FWD_WB;
    if (hits(regWriteM, writeRegM, rtE))      forwardBE = FWD_MEM;
    else if (hits(regWriteW, writeRegW, rtE)) forwardBE = FWD_WB;
    forwardAD = hits(regWriteM, writeRegM, rsD);
    forwardBD = hits(regWriteM, writeRegM, rtD);
  end

  assign lw_stall = hits(memToRegE, writeRegE, rsD) || hits(memToRegE, writeRegE, rtD);
  assign br_stall = branchD &&
                    (hits(regWriteE, writeRegE, rsD) || hits(regWriteE, writeRegE, rtD) ||
                     hits(memToRegM, writeRegM, rsD) || hits(memToRegM, writeRegM, rtD));
  assign mem_wait = memAccessM && !dmemReady;

  // A dmem wait freezes everything; pending flushes are deferred until it clears.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (mem_wait) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (lw_stall || br_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (pcSrcD) begin
      flushD = 1'b1;
    end
  end

  // The cycle that enters MEM_WAIT counts as the first wait cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      memTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
            if (WAIT_W'(1) == WAIT_MAX) memTimeout <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_wait) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
            if ((wait_cnt + 1'b1) == WAIT_MAX) memTimeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign fsm_state = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stallF),
    .count (stallCycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flushD || flushE),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit built with 4-bit counters so that
// saturation is reachable in a few cycles.
module tb_hazard_control_unit;
  import hazard_control_unit_pkg::*;

  localparam int REG_AW   = 5;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic              regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
  logic              branchD, pcSrcD, memAccessM, dmemReady;
  logic [1:0]        forwardAE, forwardBE;
  logic              forwardAD, forwardBD;
  logic              stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic              memTimeout;
  logic [CNT_W-1:0]  stallCycles, flushCount;
  hcu_state_e        fsm_state;

  int checks = 0;
  int errors = 0;

  hazard_control_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .pcSrcD(pcSrcD), .memAccessM(memAccessM), .dmemReady(dmemReady),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .memTimeout(memTimeout), .stallCycles(stallCycles), .flushCount(flushCount),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic drive_idle();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeRegE = '0; writeRegM = '0; writeRegW = '0;
    regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
    memToRegE = 1'b0; memToRegM = 1'b0;
    branchD = 1'b0; pcSrcD = 1'b0; memAccessM = 1'b0; dmemReady = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_stalls(input string tag, input logic [6:0] exp);
    check(tag, {stallF, stallD, stallE, stallM, flushD, flushE, flushW}, {25'd0, exp});
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    #1;
    do_reset();

    check("reset_state", fsm_state, RUN);
    check("reset_timeout", memTimeout, 0);
    check("reset_stallcnt", stallCycles, 0);
    check("reset_flushcnt", flushCount, 0);
    check_stalls("reset_idle_ctl", 7'b0000000);

    // Forwarding: M beats W, then W alone
    rsE = 5'd3; rtE = 5'd3; regWriteM = 1'b1; writeRegM = 5'd3; regWriteW = 1'b1; writeRegW = 5'd3;
    rsD = 5'd3; rtD = 5'd4;
    #1;
    check("fwdAE_mem_wins", forwardAE, 2'b10);
    check("fwdBE_mem_wins", forwardBE, 2'b10);
    check("fwdAD_hit", forwardAD, 1);
    check("fwdBD_miss", forwardBD, 0);
    regWriteM = 1'b0;
    #1;
    check("fwdAE_wb", forwardAE, 2'b01);
    check("fwdAD_off", forwardAD, 0);
    regWriteW = 1'b0;
    #1;
    check("fwdAE_rf", forwardAE, 2'b00);

    // Register 0 never forwards
    regWriteM = 1'b1; writeRegM = 5'd0; regWriteW = 1'b1; writeRegW = 5'd0;
    rsE = 5'd0; rtE = 5'd0; rsD = 5'd0; rtD = 5'd0;
    #1;
    check("fwdAE_r0", forwardAE, 2'b00);
    check("fwdBE_r0", forwardBE, 2'b00);
    check("fwdAD_r0", forwardAD, 0);
    drive_idle();
    tick();

    // Load-use stall for one cycle
    memToRegE = 1'b1; writeRegE = 5'd5; rtD = 5'd5;
    #1;
    check_stalls("lw_stall_ctl", 7'b1100010);
    tick();
    drive_idle();
    #1;
    check("lw_stallcnt", stallCycles, 1);
    check("lw_flushcnt", flushCount, 1);
    check_stalls("lw_released", 7'b0000000);

    // Branch stall beats a taken branch
    branchD = 1'b1; pcSrcD = 1'b1; regWriteE = 1'b1; writeRegE = 5'd7; rsD = 5'd7;
    #1;
    check_stalls("br_stall_ctl", 7'b1100010);
    regWriteE = 1'b0; memToRegM = 1'b1; writeRegM = 5'd7;
    #1;
    check_stalls("br_stall_loadM", 7'b1100010);
    tick();
    drive_idle();
    #1;
    check("br_stallcnt", stallCycles, 2);
    check("br_flushcnt", flushCount, 2);

    // Taken branch flush, then overridden by memWait within the same cycle
    branchD = 1'b1; pcSrcD = 1'b1;
    #1;
    check_stalls("taken_flushD", 7'b0000100);
    memAccessM = 1'b1; dmemReady = 1'b0;
    #1;
    check_stalls("memwait_over_branch", 7'b1111001);
    drive_idle();
    tick();
    check("branch_flushcnt", flushCount, 2);
    check("branch_state", fsm_state, RUN);

    // Three-cycle memory wait
    do_reset();
    memAccessM = 1'b1; dmemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait3_stall", stallF, 1);
      tick();
      check("wait3_state", fsm_state, MEM_WAIT);
    end
    dmemReady = 1'b1;
    #1;
    check_stalls("wait3_ready_ctl", 7'b0000000);
    tick();
    check("wait3_back_run", fsm_state, RUN);
    check("wait3_timeout", memTimeout, 0);
    check("wait3_stallcnt", stallCycles, 3);
    drive_idle();

    // Timeout after MAX_WAIT wait cycles; stallCycles saturates at 4'hF
    do_reset();
    memAccessM = 1'b1; dmemReady = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      check("timeout_not_yet", memTimeout, 0);
      tick();
    end
    check("timeout_set", memTimeout, 1);
    check("stallcnt_sat", stallCycles, 4'hF);
    check_stalls("timeout_still_stalls", 7'b1111001);
    tick();
    check("stallcnt_hold", stallCycles, 4'hF);
    check("timeout_flushcnt", flushCount, 0);
    dmemReady = 1'b1;
    tick();
    check("timeout_sticky", memTimeout, 1);
    check("timeout_state_run", fsm_state, RUN);
    do_reset();
    check("rst_timeout_clr", memTimeout, 0);
    check("rst_stallcnt_clr", stallCycles, 0);
    check("rst_flushcnt_clr", flushCount, 0);
    check("rst_state_run", fsm_state, RUN);

    // Reset mid-wait: FSM returns to RUN while stalls follow inputs
    memAccessM = 1'b1; dmemReady = 1'b0;
    tick();
    tick();
    check("midwait_state", fsm_state, MEM_WAIT);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_stall", stallF, 1);
    tick();
    check("midwait_rst_state", fsm_state, RUN);
    check("midwait_rst_cnt", stallCycles, 0);
    rst_n = 1'b1;
    drive_idle();
    tick();

    // flushCount saturation via a held load-use hazard
    memToRegE = 1'b1; writeRegE = 5'd9; rsD = 5'd9;
    for (int i = 0; i < 17; i++) tick();
    check("flushcnt_sat", flushCount, 4'hF);
    check("stallcnt_sat2", stallCycles, 4'hF);
    drive_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
